// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the ysyx_23060096 instruction fetch unit.
package ysyx_23060096_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_OUT  = 3'd4
    } ifu_state_e;

    // addi x0, x0, 0 -- handed to decode when a fetch faults before memory is touched
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060096_ifu.sv
// Multi-cycle instruction fetch unit: holds the PC, issues one imem read at a
// time, and hands instruction + PC to decode over a valid/ready handshake.
// Execute redirects are accepted in every state; stale responses are dropped.
module ysyx_23060096_ifu
    import ysyx_23060096_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            id_fault_q, id_fault_d;
    logic            pc_misaligned;

    // A misaligned pc never reaches memory; it is turned into a faulting NOP instead.
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // Outputs depend only on registered state, never on inputs.
    assign imem_req_valid = (state_q == S_REQ) && !pc_misaligned;
    assign imem_req_addr  = pc_q;
    assign id_valid       = (state_q == S_OUT);
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;
    assign id_fault       = id_fault_q;

    // Next-state and register updates; a redirect always overrides pc+4.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_fault_d = id_fault_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // Only a request actually accepted leaves a response to discard.
                    if (imem_req_ready && !pc_misaligned) begin
                        state_d = S_DROP;
                    end
                end else if (pc_misaligned) begin
                    id_inst_d  = XLEN'(NOP);
                    id_pc_d    = pc_q;
                    id_fault_d = 1'b1;
                    state_d    = S_OUT;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // Response in the same cycle is stale: nothing left in flight.
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    id_inst_d  = imem_rsp_data;
                    id_pc_d    = pc_q;
                    id_fault_d = imem_rsp_err;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_OUT;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end

            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= XLEN'(RESET_PC);
            id_inst_q  <= XLEN'(NOP);
            id_pc_q    <= '0;
            id_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_fault_q <= id_fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Directed testbench for ysyx_23060096_ifu.
module tb_ysyx_23060096_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_err;

    ysyx_23060096_ifu #(
        .RESET_PC(32'h8000_0000),
        .XLEN    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_fault      (id_fault),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid",  32'(id_valid),       32'd0);
        chk("rst_id_inst",   id_inst,             32'h0000_0013);
        chk("rst_id_pc",     id_pc,               32'h0);
        chk("rst_id_fault",  32'(id_fault),       32'd0);
        chk("rst_addr",      imem_req_addr,       32'h8000_0000);
        rst_n = 1'b1;

        // First fetch, zero-wait memory
        tick();
        chk("f1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("f1_req_addr",  imem_req_addr,       32'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("f1_wait_req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0297;
        tick();
        imem_rsp_valid = 1'b0;
        chk("f1_id_valid", 32'(id_valid), 32'd1);
        chk("f1_id_inst",  id_inst,       32'h0000_0297);
        chk("f1_id_pc",    id_pc,         32'h8000_0000);
        chk("f1_id_fault", 32'(id_fault), 32'd0);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_id_valid",  32'(id_valid),       32'd1);
            chk("stall_id_inst",   id_inst,             32'h0000_0297);
            chk("stall_id_pc",     id_pc,               32'h8000_0000);
            chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("f2_req_valid", 32'(imem_req_valid), 32'd1);
        chk("f2_req_addr",  imem_req_addr,       32'h8000_0004);
        chk("f2_id_valid",  32'(id_valid),       32'd0);

        // Redirect while waiting; late response must be dropped
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("drop2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("drop2_id_valid",  32'(id_valid),       32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        tick();
        imem_rsp_valid = 1'b0;
        chk("redir_id_valid",  32'(id_valid),       32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr",  imem_req_addr,       32'h8000_0100);

        // Redirect and response in the same WAIT cycle
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_2222;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("same_id_valid",  32'(id_valid),       32'd0);
        chk("same_req_valid", 32'(imem_req_valid), 32'd1);
        chk("same_req_addr",  imem_req_addr,       32'h8000_0200);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mis_req_addr",  imem_req_addr,       32'h8000_0102);
        tick();
        chk("mis_id_valid",  32'(id_valid),       32'd1);
        chk("mis_id_fault",  32'(id_fault),       32'd1);
        chk("mis_id_inst",   id_inst,             32'h0000_0013);
        chk("mis_id_pc",     id_pc,               32'h8000_0102);
        chk("mis_out_req",   32'(imem_req_valid), 32'd0);

        // Redirect in OUT together with id_ready
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        chk("out_redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("out_redir_req_addr",  imem_req_addr,       32'h8000_0300);
        chk("out_redir_id_valid",  32'(id_valid),       32'd0);

        // Access fault on response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("err_id_valid", 32'(id_valid), 32'd1);
        chk("err_id_fault", 32'(id_fault), 32'd1);
        chk("err_id_pc",    id_pc,         32'h8000_0300);
        chk("err_id_inst",  id_inst,       32'h1234_5678);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("err_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("err_next_req_addr",  imem_req_addr,       32'h8000_0304);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ok_id_fault", 32'(id_fault), 32'd0);
        chk("ok_id_pc",    id_pc,         32'h8000_0304);
        chk("ok_id_inst",  id_inst,       32'h0010_0093);

        // Reset in the middle of a fetch
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mrst_id_valid",  32'(id_valid),       32'd0);
        chk("mrst_addr",      imem_req_addr,       32'h8000_0000);
        chk("mrst_id_pc",     id_pc,               32'h0);
        chk("mrst_id_inst",   id_inst,             32'h0000_0013);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("mrst_restart_addr",  imem_req_addr,       32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_ifu.md
# ysyx_23060096_ifu

Instruction fetch unit of the multi-cycle NPC core, directly upstream of the decode stage and its key-indexed opcode/funct lookup muxes. It holds the PC and issues one instruction-memory read at a time over a valid/ready request channel. It captures the response and presents instruction plus PC to decode through a valid/ready handshake. It accepts control-flow redirects from execute at any point, discarding stale in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  single clock; everything is on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  read data valid, one-cycle pulse per accepted request
- imem_rsp_data  in  XLEN  instruction word
- imem_rsp_err  in  1  access fault on this response
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode consumes instruction
- id_inst  out  XLEN  instruction word
- id_pc  out  XLEN  PC of id_inst
- id_fault  out  1  instruction carries fetch fault (access or misaligned)
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_pc  in  XLEN  redirect target

## Operation
- States: IDLE, REQ, WAIT, DROP, OUT. Registered: state, pc, id_inst, id_pc, id_fault.
- IDLE: entered only by reset; next cycle goes to REQ.
- REQ: imem_req_valid=1, addr=pc.
  - If pc[1:0]!=0: no request. Go to OUT with id_fault=1, id_inst=NOP, id_pc=pc.
  - req_ready without redirect: go to WAIT.
  - Redirect without req_ready: pc<=redirect_pc, stay in REQ.
  - Redirect with req_ready: pc<=redirect_pc, go to DROP.
- WAIT:
  - rsp_valid without redirect: id_inst<=rsp_data, id_pc<=pc, id_fault<=rsp_err, pc<=pc+4 (mod 2^XLEN), go to OUT.
  - Redirect without rsp_valid: pc<=redirect_pc, go to DROP.
  - Redirect with rsp_valid: response discarded, pc<=redirect_pc, go to REQ.
- DROP: imem_req_valid=0. rsp_valid is discarded, then go to REQ. A redirect here only updates pc.
- OUT: id_valid=1; id_inst, id_pc and id_fault stay stable until the handshake completes.
  - id_ready: go to REQ.
  - Redirect: pc<=redirect_pc, go to REQ, regardless of id_ready. If id_ready is high in the same cycle, the handshake still counts as completed.
- Redirect always wins over the sequential pc+4 update. Misaligned redirect targets are caught in REQ.
- imem_req_valid is never asserted in WAIT, DROP or OUT, so at most one request is outstanding.

## Timing
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, id_inst=NOP, id_pc=0, id_fault=0, imem_req_valid=0, id_valid=0.
- First request appears 1 cycle after rst_n deasserts.
- Zero-wait memory (req accepted cycle N, rsp cycle N+1): id_valid in cycle N+2. With id_ready held high, the next request goes out in N+3, so throughput is one instruction per 3 cycles.
- Outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Reset mid-fetch: state is dropped immediately and fetch restarts at RESET_PC. The memory side must also be reset.

## Structure
- Shared package ysyx_23060096_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DROP/OUT)
  - NOP = 32'h0000_0013
  - the default RESET_PC constant
- No sub-module: the FSM, pc and output registers live in one module. The pc+4 adder is inline.

## Test plan
- Reset release, memory always ready, rsp one cycle later with data 32'h00000297 → request addr 32'h80000000 at cycle 1; id_valid at cycle 3 with id_pc=32'h80000000; next request addr 32'h80000004.
- id_ready held low for 5 cycles in OUT → id_valid, id_inst and id_pc are stable throughout; no new imem_req_valid; fetch resumes 1 cycle after id_ready.
- Redirect to 32'h80000100 while in WAIT, rsp arriving 2 cycles later → that response is dropped; id_valid stays low; next request addr is 32'h80000100.
- Redirect and rsp_valid in the same WAIT cycle → rsp is discarded and the next request goes to the redirect target.
- Redirect to 32'h80000102 → no memory request; id_valid with id_fault=1, id_inst=32'h00000013, id_pc=32'h80000102.
- rsp_err=1 on a fetch → id_fault=1 alongside that PC; the next fetch is pc+4 with fault cleared.
